gf163_mul_host: RTL and testbench

GF163_MUL_HOST -- requirements
Module: gf163_mul_host

---
 rtl/gf163_mul_host.sv | 174 +++++++++++++++++
 tb/tb_gf163_mul_host.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gf163_mul_host.sv
// Host sequencer for a word-serial GF(2^163) multiplier: streams 16-bit operand
// words out, then assembles the 11-word result stream back into a 163-bit product.
module gf163_mul_host #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [162:0] a,
  input  logic [162:0] b,
  input  logic [162:0] g,
  output logic         busy,
  output logic         done,
  output logic [162:0] p,
  output logic [1:0]   err,
  output logic         mul_ctr,
  output logic [15:0]  mul_a,
  output logic [15:0]  mul_b,
  output logic [15:0]  mul_g,
  input  logic [15:0]  mul_po,
  input  logic         mul_ctro
);

  localparam int unsigned OPW = 163;
  localparam int unsigned WW  = 16;
  localparam int unsigned AW  = OPW - WW;  // assembly bits kept before the last word
  localparam int unsigned TW  = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [3:0]  K_LAST = 4'd12;
  localparam logic [3:0]  W_LAST = 4'd10;

  typedef enum logic [1:0] {IDLE, SEND, WAIT, RECV} state_t;

  state_t          state_q, state_d;
  logic [3:0]      k_q, k_d;
  logic [TW-1:0]   t_q, t_d;
  logic [3:0]      w_q, w_d;
  logic [OPW-1:0]  a_q, a_d, b_q, b_d, g_q, g_d;
  logic [AW-1:0]   asm_q, asm_d;
  logic [OPW-1:0]  p_d;
  logic [1:0]      err_d;
  logic            done_d, busy_d, ctr_d;
  logic [WW-1:0]   mul_a_d, mul_b_d, mul_g_d;

  // Word idx of the operand zero-extended to 176 bits; idx is at most 10.
  function automatic logic [WW-1:0] word_of(input logic [OPW-1:0] x, input logic [3:0] idx);
    logic [175:0] ext;
    ext = {13'b0, x};
    return ext[{idx, 4'b0000} +: WW];
  endfunction

  // Next-state logic; outputs are decoded from the next state so they register in step.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    t_d     = t_q;
    w_d     = w_q;
    a_d     = a_q;
    b_d     = b_q;
    g_d     = g_q;
    asm_d   = asm_q;
    p_d     = p;
    err_d   = err;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        // The done cycle still belongs to the finished operation.
        if (start && !done) begin
          state_d = SEND;
          k_d     = 4'd0;
          t_d     = '0;
          w_d     = 4'd0;
          a_d     = a;
          b_d     = b;
          g_d     = g;
        end
      end
      SEND: begin
        if (k_q == K_LAST) begin
          state_d = WAIT;
          t_d     = '0;
        end else begin
          k_d = k_q + 4'd1;
        end
      end
      WAIT: begin
        if (mul_ctro) begin
          asm_d   = {asm_q[AW-WW-1:0], mul_po};
          w_d     = 4'd1;
          state_d = RECV;
        end else if (t_q == TW'(TIMEOUT)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          err_d   = 2'b01;
        end else begin
          t_d = t_q + TW'(1);
        end
      end
      RECV: begin
        if (!mul_ctro) begin
          state_d = IDLE;
          done_d  = 1'b1;
          err_d   = 2'b10;
        end else if (w_q == W_LAST) begin
          // Upper 13 bits of the 176-bit stream have already shifted out of asm_q.
          p_d     = {asm_q, mul_po};
          err_d   = 2'b00;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          asm_d = {asm_q[AW-WW-1:0], mul_po};
          w_d   = w_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d  = (state_d != IDLE);
    ctr_d   = 1'b0;
    mul_a_d = '0;
    mul_b_d = '0;
    mul_g_d = '0;
    if (state_d == SEND) begin
      if (k_d <= 4'd10) begin
        mul_b_d = word_of(b_d, 4'd10 - k_d);
      end
      if ((k_d >= 4'd1) && (k_d <= 4'd11)) begin
        ctr_d   = 1'b1;
        mul_a_d = word_of(a_d, 4'd11 - k_d);
        mul_g_d = word_of(g_d, 4'd11 - k_d);
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= 4'd0;
      t_q     <= '0;
      w_q     <= 4'd0;
      a_q     <= '0;
      b_q     <= '0;
      g_q     <= '0;
      asm_q   <= '0;
      p       <= '0;
      err     <= 2'b00;
      done    <= 1'b0;
      busy    <= 1'b0;
      mul_ctr <= 1'b0;
      mul_a   <= '0;
      mul_b   <= '0;
      mul_g   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      t_q     <= t_d;
      w_q     <= w_d;
      a_q     <= a_d;
      b_q     <= b_d;
      g_q     <= g_d;
      asm_q   <= asm_d;
      p       <= p_d;
      err     <= err_d;
      done    <= done_d;
      busy    <= busy_d;
      mul_ctr <= ctr_d;
      mul_a   <= mul_a_d;
      mul_b   <= mul_b_d;
      mul_g   <= mul_g_d;
    end
  end

endmodule

// File: tb/tb_gf163_mul_host.sv
// Directed scoreboard bench for gf163_mul_host: expected send beats and results
// are queued when stimulus is issued and compared as the DUT produces them.
module tb_gf163_mul_host;

  localparam int unsigned TO = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [162:0] a, b, g;
  logic         busy, done;
  logic [162:0] p;
  logic [1:0]   err;
  logic         mul_ctr;
  logic [15:0]  mul_a, mul_b, mul_g;
  logic [15:0]  mul_po;
  logic         mul_ctro;

  gf163_mul_host #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .g(g),
    .busy(busy), .done(done), .p(p), .err(err),
    .mul_ctr(mul_ctr), .mul_a(mul_a), .mul_b(mul_b), .mul_g(mul_g),
    .mul_po(mul_po), .mul_ctro(mul_ctro)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ctr;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] g;
  } beat_t;

  typedef struct packed {
    logic [162:0] p;
    logic [1:0]   err;
  } res_t;

  beat_t        send_q[$];
  res_t         res_q[$];
  int           checks = 0;
  int           errors = 0;
  int           ctr_rises = 0;
  int           done_pulses = 0;
  logic         ctr_prev = 1'b0;
  logic [162:0] last_p = '0;

  // Independent event counters for strobe-level checks.
  always @(posedge clk) begin
    ctr_prev <= mul_ctr;
    if (mul_ctr && !ctr_prev) ctr_rises <= ctr_rises + 1;
    if (done) done_pulses <= done_pulses + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [162:0] rnd163();
    logic [191:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return 163'(r);
  endfunction

  function automatic logic [15:0] wd(input logic [162:0] x, input int i);
    logic [175:0] e;
    e = {13'b0, x};
    return e[i*16 +: 16];
  endfunction

  // Queue the 13 expected SEND beats for operands x/y/z.
  task automatic push_send(input logic [162:0] xa, input logic [162:0] xb, input logic [162:0] xg);
    beat_t bt;
    for (int k = 0; k < 13; k++) begin
      bt.ctr = (k >= 1 && k <= 11);
      bt.b   = (k <= 10) ? wd(xb, 10 - k) : 16'h0000;
      bt.a   = (k >= 1 && k <= 11) ? wd(xa, 11 - k) : 16'h0000;
      bt.g   = (k >= 1 && k <= 11) ? wd(xg, 11 - k) : 16'h0000;
      send_q.push_back(bt);
    end
  endtask

  // Pulse start for one cycle, then scramble the operand inputs.
  task automatic start_op(input logic [162:0] xa, input logic [162:0] xb, input logic [162:0] xg);
    push_send(xa, xb, xg);
    a = xa; b = xb; g = xg;
    start = 1'b1;
    tick();
    start = 1'b0;
    a = rnd163(); b = rnd163(); g = rnd163();
  endtask

  task automatic check_send(input int pulse_k, output int nctr);
    beat_t bt;
    nctr = 0;
    for (int k = 0; k < 13; k++) begin
      bt = send_q.pop_front();
      checks++;
      if ({mul_ctr, mul_a, mul_b, mul_g} !== bt) begin
        errors++;
        $display("FAIL send_k%0d: got ctr=%b a=%h b=%h g=%h, want ctr=%b a=%h b=%h g=%h",
                 k, mul_ctr, mul_a, mul_b, mul_g, bt.ctr, bt.a, bt.b, bt.g);
      end
      if (mul_ctr === 1'b1) nctr++;
      if (k == pulse_k) start = 1'b1;
      tick();
      start = 1'b0;
    end
  endtask

  // Feed n result words of stream s after delay idle WAIT cycles; ctro is left high.
  task automatic respond(input int delay, input int n, input logic [175:0] s, input int pulse_d);
    mul_ctro = 1'b0;
    for (int d = 0; d < delay; d++) begin
      if (d == pulse_d) start = 1'b1;
      tick();
      start = 1'b0;
    end
    for (int i = 0; i < n; i++) begin
      mul_ctro = 1'b1;
      mul_po   = s[175 - 16*i -: 16];
      tick();
    end
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < budget) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    checks++;
    if ({busy, done, p, err, mul_ctr, mul_a, mul_b, mul_g} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b err=%b ctr=%b p=%h, want all zero",
               busy, done, err, mul_ctr, p);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b, want 0", busy);
    end
  endtask

  // Leaves the DUT in its first WAIT cycle for test_good_result.
  task automatic test_single();
    int nctr;
    start_op(163'h1, 163'h2, 163'h1920);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL single_busy: got %b, want 1", busy);
    end
    check_send(-1, nctr);
    checks++;
    if (nctr != 11) begin
      errors++;
      $display("FAIL single_ctr_len: got %0d, want 11", nctr);
    end
  endtask

  task automatic test_good_result();
    logic [175:0] s;
    logic [162:0] pv;
    res_t         r, exp_r;
    int           cyc;
    int           dp0;
    s = {16'h0007, {9{16'hFFFF}}, 16'hABCD};
    exp_r.p = s[162:0]; exp_r.err = 2'b00;
    res_q.push_back(exp_r);
    dp0 = done_pulses;
    respond(5, 11, s, -1);
    wait_done(3, cyc);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL good_done: got done=%b after %0d cycles, want 1", done, cyc);
    end
    r = res_q.pop_front();
    checks++;
    if (p !== r.p || err !== r.err) begin
      errors++;
      $display("FAIL good_result: got p=%h err=%b, want p=%h err=%b", p, err, r.p, r.err);
    end
    pv = p;
    checks++;
    if (pv[15:0] !== 16'hABCD || pv[162:160] !== 3'b111) begin
      errors++;
      $display("FAIL good_words: got lsw=%h top=%b, want lsw=abcd top=111", pv[15:0], pv[162:160]);
    end
    last_p = r.p;
    tick();
    mul_ctro = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || done_pulses - dp0 != 1) begin
      errors++;
      $display("FAIL good_once: got done=%b busy=%b pulses=%0d, want 0 0 1",
               done, busy, done_pulses - dp0);
    end
  endtask

  task automatic test_timeout();
    res_t r, exp_r;
    int   cyc, nctr;
    tick();
    start_op(rnd163(), rnd163(), rnd163());
    check_send(-1, nctr);
    exp_r.p = last_p; exp_r.err = 2'b01;
    res_q.push_back(exp_r);
    mul_ctro = 1'b0;
    wait_done(20, cyc);
    checks++;
    if (done !== 1'b1 || cyc != 9) begin
      errors++;
      $display("FAIL timeout_latency: got done=%b at %0d cycles, want 1 at 9", done, cyc);
    end
    r = res_q.pop_front();
    checks++;
    if (p !== r.p || err !== r.err) begin
      errors++;
      $display("FAIL timeout_result: got p=%h err=%b, want p=%h err=%b", p, err, r.p, r.err);
    end
  endtask

  task automatic test_short_burst();
    res_t r, exp_r;
    int   cyc, nctr;
    tick();
    start_op(rnd163(), rnd163(), rnd163());
    check_send(-1, nctr);
    exp_r.p = last_p; exp_r.err = 2'b10;
    res_q.push_back(exp_r);
    respond(2, 4, {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), 16'h1234}, -1);
    mul_ctro = 1'b0;
    wait_done(3, cyc);
    checks++;
    if (done !== 1'b1 || cyc != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL short_done: got done=%b cyc=%0d busy=%b, want 1 1 0", done, cyc, busy);
    end
    r = res_q.pop_front();
    checks++;
    if (p !== r.p || err !== r.err) begin
      errors++;
      $display("FAIL short_result: got p=%h err=%b, want p=%h err=%b", p, err, r.p, r.err);
    end
  endtask

  task automatic test_reset_mid_recv();
    logic [175:0] s;
    res_t         r, exp_r;
    int           cyc, nctr, dp0;
    tick();
    dp0 = done_pulses;
    start_op(rnd163(), rnd163(), rnd163());
    check_send(-1, nctr);
    respond(1, 5, {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), 16'h5555}, -1);
    rst = 1'b1;
    tick();
    mul_ctro = 1'b0;
    checks++;
    if ({busy, done, p, err, mul_ctr, mul_a, mul_b, mul_g} !== '0) begin
      errors++;
      $display("FAIL rst_recv_outputs: got busy=%b done=%b err=%b ctr=%b p=%h, want all zero",
               busy, done, err, mul_ctr, p);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (done_pulses != dp0) begin
      errors++;
      $display("FAIL rst_recv_nodone: got %0d pulses, want 0", done_pulses - dp0);
    end
    last_p = '0;
    start_op(rnd163(), rnd163(), rnd163());
    check_send(-1, nctr);
    s = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), 16'h0F0F};
    exp_r.p = s[162:0]; exp_r.err = 2'b00;
    res_q.push_back(exp_r);
    respond(0, 11, s, -1);
    mul_ctro = 1'b0;
    wait_done(3, cyc);
    r = res_q.pop_front();
    checks++;
    if (done !== 1'b1 || p !== r.p || err !== r.err) begin
      errors++;
      $display("FAIL rst_recv_second: got done=%b p=%h err=%b, want 1 p=%h err=%b",
               done, p, err, r.p, r.err);
    end
    last_p = r.p;
  endtask

  task automatic test_back_to_back();
    logic [175:0] s;
    logic [162:0] na, nb, ng;
    res_t         r, exp_r;
    int           cyc, nctr, r0;
    tick();
    r0 = ctr_rises;
    start_op(rnd163(), rnd163(), rnd163());
    check_send(5, nctr);
    s = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), 16'h2468};
    exp_r.p = s[162:0]; exp_r.err = 2'b00;
    res_q.push_back(exp_r);
    respond(3, 11, s, 1);
    mul_ctro = 1'b0;
    wait_done(3, cyc);
    r = res_q.pop_front();
    checks++;
    if (done !== 1'b1 || p !== r.p || err !== r.err) begin
      errors++;
      $display("FAIL b2b_first: got done=%b p=%h err=%b, want 1 p=%h err=%b",
               done, p, err, r.p, r.err);
    end
    na = rnd163(); nb = rnd163(); ng = rnd163();
    push_send(na, nb, ng);
    a = na; b = nb; g = ng;
    start = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done_cycle_start: got busy=%b, want 0", busy);
    end
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_next_cycle_start: got busy=%b, want 1", busy);
    end
    check_send(-1, nctr);
    s = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), 16'h1357};
    exp_r.p = s[162:0]; exp_r.err = 2'b00;
    res_q.push_back(exp_r);
    respond(2, 11, s, -1);
    mul_ctro = 1'b0;
    wait_done(3, cyc);
    r = res_q.pop_front();
    checks++;
    if (done !== 1'b1 || p !== r.p || err !== r.err) begin
      errors++;
      $display("FAIL b2b_second: got done=%b p=%h err=%b, want 1 p=%h err=%b",
               done, p, err, r.p, r.err);
    end
    tick();
    checks++;
    if (ctr_rises - r0 != 2) begin
      errors++;
      $display("FAIL b2b_ctr_sequences: got %0d, want 2", ctr_rises - r0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    a = '0; b = '0; g = '0;
    mul_ctro = 1'b0; mul_po = '0;
    test_reset();
    test_single();
    test_good_result();
    test_timeout();
    test_short_burst();
    test_reset_mid_recv();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
